led_gradient_mixer: RTL and testbench
=====================================

# led_gradient_mixer

Multi-channel, sequential successor of the LED colour mixer: maps a counter position against a midpoint/maximum onto a red→yellow→green gradient for up to CHANNELS LEDs. A shared shift-subtract divider replaces the combinational 64-bit divide, so the block meets timing for large N. It sits between the game-state logic, which issues one request per LED update, and the LED driver, which reads the packed colour bus.

## Interface
- N, 10: width of contador / mid_idx / max_idx.
- CHANNELS, 4: number of LEDs held; cor_led slice k = bits [24k+23:24k].
- COR_MAX, 190: full intensity of an active component.
- GANHO, 320: gradient slope numerator; legal range 1..511.
- FADE_STEP, 8: max per-component change per fade tick (used only with fade compiled in).
- FADE_DIV, 1024: clocks per fade tick (used only with fade compiled in).
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle; request accepted on edge with req_valid && req_ready.
- req_canal  in  max(1,$clog2(CHANNELS))  target LED.
- contador  in  N  current position.
- mid_idx  in  N  yellow point.
- max_idx  in  N  full-green point.
- cor_led  out  24*CHANNELS  registered {R,G,B} per LED.
- done  out  1  one-cycle pulse when a request's result is written.

## Operation
- FSM: IDLE → SETUP → DIVIDE → WRITE → IDLE; req_ready = (state == IDLE), combinational.
- Accept: register req_canal, contador, mid_idx, max_idx; move to SETUP.
- SETUP classifies the request. cnt == mid: no divide; go straight to WRITE with {COR_MAX, COR_MAX, 0}.
- cnt < mid: numerator = cnt*GANHO, denominator = mid.
- cnt > mid: numerator = (cnt−mid)*GANHO, denominator = (max > mid) ? max−mid : 1.
- DIVIDE: restoring divide over DW = N+9 bits, one quotient bit per clock, exactly DW cycles. Numerator is DW bits wide; denominator is N bits, zero-extended.
- Quotient q saturates to COR_MAX when q > COR_MAX.
- WRITE, cnt < mid: {COR_MAX, q, 0}.
- WRITE, cnt > mid: {COR_MAX − q, COR_MAX, 0}. B is always 0.
- WRITE updates only slice req_canal and pulses done. req_canal ≥ CHANNELS: no slice changes, but done still pulses.
- Busy: req_valid outside IDLE is ignored; the requester holds its request until ready.
- Reset, including mid-operation: state IDLE, every cor_led bit 0, done 0, in-flight request discarded, no done pulse.

## Timing
- Acceptance edge is E0. Divide path: SETUP at E1, DIVIDE over E2..E(DW+1), WRITE update and done visible after E(DW+2). That is 21 edges for N=10.
- Equal path: update and done visible after E2.
- req_ready returns high in the cycle done is high, so back-to-back requests can be accepted on that edge.
- All outputs are registered except req_ready.

## Configuration
- LED_MIXER_FADE_EN defined: WRITE loads a per-channel target register, and cor_led is a separate displayed register.
  - A prescaler counts FADE_DIV clocks.
  - On each tick, every component of every channel moves toward its target by min(FADE_STEP, |diff|).
  - done still pulses at target write.
  - Targets and displayed values reset to 0.
- LED_MIXER_FADE_EN undefined: WRITE drives cor_led directly. FADE_STEP and FADE_DIV are ignored, and no prescaler or target registers exist.

## Structure
- Package led_mixer_pkg holds:
  - FSM state enum;
  - default COR_MAX and GANHO constants;
  - a DW width function (N+9);
  - a colour-packing function {R,G,B} → 24 bits.
- Sub-module led_seq_divider: restoring divider with ports start, numerator[DW], denominator[N], quotient[DW] and done. It runs a fixed DW cycles and has no divide-by-zero path, because the caller guarantees the denominator is ≥ 1.

## Test plan
1. Reset asserted: cor_led = 0, done = 0, req_ready = 1. Release, then idle 5 cycles: cor_led unchanged.
2. cnt=500, mid=500, max=1000, canal 2 → slice 2 = 0xBEBE00 after E2; other slices 0; single done pulse.
3. cnt=100, mid=400, canal 0 → q=32000/400=80, slice 0 = 0xBE5000 after E21. cnt=399, mid=400 → q=319 saturates, slice 0 = 0xBEBE00.
4. cnt=600, mid=500, max=1000, canal 1 → q=64, slice 1 = 0x7EBE00. cnt=502, mid=500, max=400 → denominator 1, slice 1 = 0x00BE00.
5. req_valid held high during DIVIDE with different data → ignored, first result written, second accepted on the done cycle. Canal 5 → done pulses, no slice changes.
6. reset_n low for 1 cycle at E10 of a divide → all outputs 0, no done. With LED_MIXER_FADE_EN, FADE_DIV=4, target 0xBE5000 from 0 → R steps 8, 16, … reaching 190 after 24 ticks; G reaches 80 after 10 ticks.

Source files
------------

// File: rtl/led_mixer_pkg.sv
// Shared types and helpers for the LED gradient mixer.
package led_mixer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_WRITE  = 2'd3
  } mixer_state_e;

  localparam int COR_MAX_DEF = 190;
  localparam int GANHO_DEF   = 320;

  // The numerator is a position times a slope of up to 9 bits.
  function automatic int div_width(input int n);
    return n + 9;
  endfunction

  function automatic logic [23:0] pack_rgb(input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/led_seq_divider.sv
// Restoring shift-subtract divider: one quotient bit per clock, DW clocks
// per divide. The caller guarantees denominator >= 1.
// done is high during the clock whose edge produces the final quotient bit,
// so the quotient is complete in the following cycle.
module led_seq_divider
  import led_mixer_pkg::*;
#(
  parameter int N  = 10,
  parameter int DW = div_width(N)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [DW-1:0] numerator,
  input  logic [N-1:0]  denominator,
  output logic [DW-1:0] quotient,
  output logic          done
);

  localparam int CTW = $clog2(DW + 1);

  logic [N-1:0]   rem;
  logic [N-1:0]   den_r;
  logic [CTW-1:0] cnt;
  logic [N:0]     shifted;
  logic [N:0]     diff;
  logic           fits;

  // Next partial remainder and the trial subtraction for this bit.
  always_comb begin
    shifted = {rem, quotient[DW-1]};
    diff    = shifted - {1'b0, den_r};
    fits    = (shifted >= {1'b0, den_r});
  end

  // Load on start, then shift one dividend bit into the remainder per clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      quotient <= '0;
      rem      <= '0;
      den_r    <= '0;
      cnt      <= '0;
    end else if (start) begin
      quotient <= numerator;
      rem      <= '0;
      den_r    <= denominator;
      cnt      <= CTW'(DW);
    end else if (cnt != '0) begin
      rem      <= fits ? diff[N-1:0] : shifted[N-1:0];
      quotient <= {quotient[DW-2:0], fits};
      cnt      <= cnt - CTW'(1);
    end
  end

  assign done = (cnt == CTW'(1));

endmodule

// File: rtl/led_gradient_mixer.sv
// Multi-channel red->yellow->green LED gradient mixer with a shared
// sequential divider. Optional fade: define LED_MIXER_FADE_EN to make
// cor_led slew toward per-channel targets instead of jumping.
//
//   state    | meaning
//   IDLE     | ready for a request
//   SETUP    | classify against midpoint, start divider if needed
//   DIVIDE   | divider running, DW clocks
//   WRITE    | update colour of the addressed channel, pulse done
module led_gradient_mixer
  import led_mixer_pkg::*;
#(
  parameter int N         = 10,
  parameter int CHANNELS  = 4,
  parameter int COR_MAX   = COR_MAX_DEF,
  parameter int GANHO     = GANHO_DEF,
  parameter int FADE_STEP = 8,
  parameter int FADE_DIV  = 1024,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int DW = div_width(N)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [CW-1:0]         req_canal,
  input  logic [N-1:0]          contador,
  input  logic [N-1:0]          mid_idx,
  input  logic [N-1:0]          max_idx,
  output logic [24*CHANNELS-1:0] cor_led,
  output logic                  done
);

  if (GANHO < 1 || GANHO > 511 || COR_MAX > 255 || FADE_STEP < 1 || FADE_DIV < 1) begin : g_bad_cfg
    $error("led_gradient_mixer: parameter out of range");
  end

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_SETUP  = ST_SETUP;
  localparam logic [1:0] S_DIVIDE = ST_DIVIDE;
  localparam logic [1:0] S_WRITE  = ST_WRITE;
  localparam logic [7:0] CMAX     = 8'(COR_MAX);

  logic [1:0]    state;
  logic [CW-1:0] canal_r;
  logic [N-1:0]  cnt_r, mid_r, max_r;
  logic [DW-1:0] num;
  logic [N-1:0]  den;
  logic [DW-1:0] div_q;
  logic          div_done;
  logic          div_start;
  logic [7:0]    q_sat;
  logic [23:0]   new_rgb;
  logic          wr_en;

  // Request sequencing; registers are held stable until WRITE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      canal_r <= '0;
      cnt_r   <= '0;
      mid_r   <= '0;
      max_r   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          canal_r <= req_canal;
          cnt_r   <= contador;
          mid_r   <= mid_idx;
          max_r   <= max_idx;
          state   <= S_SETUP;
        end
        S_SETUP:  state <= (cnt_r == mid_r) ? S_WRITE : S_DIVIDE;
        S_DIVIDE: if (div_done) state <= S_WRITE;
        S_WRITE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);

  // Divider operands for the rising or falling half of the gradient.
  always_comb begin
    if (cnt_r < mid_r) begin
      num = DW'(cnt_r) * DW'(GANHO);
      den = mid_r;
    end else begin
      num = DW'(cnt_r - mid_r) * DW'(GANHO);
      den = (max_r > mid_r) ? (max_r - mid_r) : N'(1);
    end
  end

  assign div_start = (state == S_SETUP) && (cnt_r != mid_r);

  led_seq_divider #(.N(N), .DW(DW)) u_div (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (div_start),
    .numerator   (num),
    .denominator (den),
    .quotient    (div_q),
    .done        (div_done)
  );

  // Saturate the quotient and assemble the colour for this request.
  always_comb begin
    q_sat = (div_q > DW'(COR_MAX)) ? CMAX : div_q[7:0];
    if (cnt_r == mid_r)
      new_rgb = pack_rgb(CMAX, CMAX, 8'd0);
    else if (cnt_r < mid_r)
      new_rgb = pack_rgb(CMAX, q_sat, 8'd0);
    else
      new_rgb = pack_rgb(CMAX - q_sat, CMAX, 8'd0);
  end

  assign wr_en = (state == S_WRITE);

`ifdef LED_MIXER_FADE_EN
  localparam int         PW    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [7:0] STEP8 = 8'(FADE_STEP);

  logic [24*CHANNELS-1:0] tgt_led;
  logic [PW-1:0]          presc;
  logic                   tick;

  function automatic logic [7:0] approach(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] d;
    if (cur < tgt) begin
      d = tgt - cur;
      return cur + ((d > STEP8) ? STEP8 : d);
    end else begin
      d = cur - tgt;
      return cur - ((d > STEP8) ? STEP8 : d);
    end
  endfunction

  // Target colour per channel, loaded by WRITE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tgt_led <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++)
        if (wr_en && canal_r == CW'(k)) tgt_led[24*k +: 24] <= new_rgb;
    end
  end

  // Free-running fade prescaler, ticks once every FADE_DIV clocks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) presc <= PW'(FADE_DIV - 1);
    else if (tick) presc <= PW'(FADE_DIV - 1);
    else presc <= presc - PW'(1);
  end

  assign tick = (presc == '0);

  // Displayed colour slews every component toward its target on each tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cor_led <= '0;
    end else if (tick) begin
      for (int k = 0; k < 3 * CHANNELS; k++)
        cor_led[8*k +: 8] <= approach(cor_led[8*k +: 8], tgt_led[8*k +: 8]);
    end
  end
`else
  // Displayed colour updates directly on WRITE; out-of-range channels are dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cor_led <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++)
        if (wr_en && canal_r == CW'(k)) cor_led[24*k +: 24] <= new_rgb;
    end
  end
`endif

endmodule

// File: tb/tb_led_gradient_mixer.sv
// Directed bench for led_gradient_mixer, five channels so that channel
// indices 5..7 exercise the out-of-range path.
module tb_led_gradient_mixer;

  localparam int N  = 10;
  localparam int CH = 5;
  localparam int CW = 3;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [CW-1:0]     req_canal = '0;
  logic [N-1:0]      contador = '0, mid_idx = '0, max_idx = '0;
  logic [24*CH-1:0]  cor_led;
  logic              done;

  always #5 clock = ~clock;

  led_gradient_mixer #(
    .N(N), .CHANNELS(CH), .COR_MAX(190), .GANHO(320), .FADE_STEP(8), .FADE_DIV(4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_canal (req_canal),
    .contador  (contador),
    .mid_idx   (mid_idx),
    .max_idx   (max_idx),
    .cor_led   (cor_led),
    .done      (done)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  canal;
    int          cnt, mid, mx;
    int          lat;
    logic [23:0] rgb;
  } vec_t;

  vec_t        vecs[12];
  logic [23:0] model[CH];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [24*CH-1:0] model_bus();
    logic [24*CH-1:0] b;
    for (int k = 0; k < CH; k++) b[24*k +: 24] = model[k];
    return b;
  endfunction

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic drive(input logic [2:0] c, input int cnt, input int mid, input int mx);
    req_canal = c;
    contador  = cnt[N-1:0];
    mid_idx   = mid[N-1:0];
    max_idx   = mx[N-1:0];
  endtask

  // Present a request at a falling edge; it is accepted on the next rising edge.
  task automatic issue(input logic [2:0] c, input int cnt, input int mid, input int mx);
    @(negedge clock);
    check("ready before request", req_ready, 1'b1);
    drive(c, cnt, mid, mx);
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  // Counts rising edges after the acceptance edge until done is seen.
  task automatic wait_done(input string name, input int exp_lat);
    int lat = 0;
    bit got = 0;
    while (!got && lat < 40) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (done) got = 1;
    end
    check(name, got ? lat : -1, exp_lat);
  endtask

  initial begin
    vecs[0]  = '{3'd2,  500,  500, 1000,  2, 24'hBEBE00};
    vecs[1]  = '{3'd0,  100,  400,    0, 21, 24'hBE5000};
    vecs[2]  = '{3'd0,  399,  400,    0, 21, 24'hBEBE00};
    vecs[3]  = '{3'd1,  600,  500, 1000, 21, 24'h7EBE00};
    vecs[4]  = '{3'd1,  502,  500,  400, 21, 24'h00BE00};
    vecs[5]  = '{3'd3,    0,  400, 1000, 21, 24'hBE0000};
    vecs[6]  = '{3'd4,  750,  500, 1000, 21, 24'h1EBE00};
    vecs[7]  = '{3'd3, 1023, 1023,    0,  2, 24'hBEBE00};
    vecs[8]  = '{3'd2,    7, 1000,    0, 21, 24'hBE0200};
    vecs[9]  = '{3'd5,  100,  400,    0, 21, 24'h123456};
    vecs[10] = '{3'd7,  300,  300,    0,  2, 24'h123456};
    vecs[11] = '{3'd0,    5,    0,    0, 21, 24'h00BE00};
    for (int k = 0; k < CH; k++) model[k] = '0;

    // Reset state and quiet idle.
    #12;
    check("reset cor_led", cor_led, '0);
    check("reset done", done, 1'b0);
    check("reset req_ready", req_ready, 1'b1);
    @(negedge clock) reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check("idle cor_led", cor_led, '0);

`ifndef LED_MIXER_FADE_EN
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].canal, vecs[i].cnt, vecs[i].mid, vecs[i].mx);
      wait_done($sformatf("vec%0d latency", i), vecs[i].lat);
      if (vecs[i].canal < CH) model[vecs[i].canal] = vecs[i].rgb;
      check($sformatf("vec%0d cor_led", i), cor_led, model_bus());
      @(negedge clock);
      check($sformatf("vec%0d done width", i), done, 1'b0);
    end

    // Request held during a divide: second payload waits for the done cycle.
    @(negedge clock);
    drive(3'd0, 100, 400, 0);
    req_valid = 1'b1;
    @(posedge clock);
    #1 drive(3'd1, 600, 500, 1000);
    wait_done("busy first latency", 21);
    model[0] = 24'hBE5000;
    check("busy first cor_led", cor_led, model_bus());
    check("busy ready on done", req_ready, 1'b1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    wait_done("busy second latency", 21);
    model[1] = 24'h7EBE00;
    check("busy second cor_led", cor_led, model_bus());
`else
    begin
      logic [23:0] prev, cur;
      int ticks = 0, bad = 0, guard = 0;
      issue(3'd0, 100, 400, 0);
      wait_done("fade target latency", 21);
      prev = cor_led[23:0];
      check("fade start", prev, 24'h0);
      while (prev != 24'hBE5000 && guard < 400) begin
        @(negedge clock);
        guard++;
        cur = cor_led[23:0];
        if (cur != prev) begin
          ticks++;
          if (cur !== {8'(mn(int'(prev[23:16]) + 8, 190)), 8'(mn(int'(prev[15:8]) + 8, 80)), 8'd0}) bad++;
          prev = cur;
        end
      end
      check("fade step errors", bad, 0);
      check("fade tick count", ticks, 24);
      check("fade final", cor_led[23:0], 24'hBE5000);
    end
`endif

    // Reset pulse in the middle of a divide discards the request.
    begin
      bit saw_done = 0;
      issue(3'd2, 100, 400, 0);
      repeat (9) @(posedge clock);
      @(negedge clock);
      check("busy ready low", req_ready, 1'b0);
      reset_n = 1'b0;
      #1;
      check("midreset cor_led", cor_led, '0);
      check("midreset done", done, 1'b0);
      check("midreset ready", req_ready, 1'b1);
      @(negedge clock) reset_n = 1'b1;
      repeat (25) begin
        @(negedge clock);
        if (done) saw_done = 1;
      end
      check("midreset no done", saw_done, 1'b0);
      check("midreset cor_led after", cor_led, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
